// File: rtl/power_manager_pkg.sv
// Shared definitions for the car power front-end and the downstream
// mileage counter/display stage: FSM encodings and clock/tick constants.
package power_manager_pkg;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_ARM      = 2'd1,
      ST_ON       = 2'd2,
      ST_WAIT_REL = 2'd3
   } pm_state_e;

   localparam int CLK_HZ      = 100_000_000;
   // One-second tick period, shared with the mileage counter stage.
   localparam int TICK_CYCLES = CLK_HZ;

endpackage

// File: rtl/power_manager_sync2.sv
// Two-flop synchronizer for one asynchronous key/pedal input.
module power_manager_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_p0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_p0 <= 1'b0;
         q       <= 1'b0;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/power_manager.sv
// Power/drive front-end: hold-to-power-up key, OFF/ARM/ON/WAIT_REL FSM,
// idle auto-off, and registered activate/moving for the mileage stage.
module power_manager
   import power_manager_pkg::*;
#(
   parameter int HOLD_CYCLES = 100_000_000,
   parameter int IDLE_CYCLES = 500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       power_on_btn,
   input  logic       power_off_btn,
   input  logic       throttle,
   input  logic       brake,
   input  logic       clutch,
   output logic       activate,
   output logic       moving,
   output logic [1:0] state,
   output logic       auto_off
);

   localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

   logic on_s, off_s, thr_s, brk_s, clu_s;

   power_manager_sync2 u_sync_on  (.clk(clk), .rst(rst), .d(power_on_btn),  .q(on_s));
   power_manager_sync2 u_sync_off (.clk(clk), .rst(rst), .d(power_off_btn), .q(off_s));
   power_manager_sync2 u_sync_thr (.clk(clk), .rst(rst), .d(throttle),      .q(thr_s));
   power_manager_sync2 u_sync_brk (.clk(clk), .rst(rst), .d(brake),         .q(brk_s));
   power_manager_sync2 u_sync_clu (.clk(clk), .rst(rst), .d(clutch),        .q(clu_s));

   pm_state_e        state_q, next_state;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic [CNT_W-1:0] idle_cnt, idle_nxt;
   logic             drive_req, next_moving, auto_nxt;

   assign drive_req = thr_s & ~brk_s & ~clu_s;

   always_comb begin
      next_state  = state_q;
      hold_nxt    = hold_cnt;
      idle_nxt    = idle_cnt;
      auto_nxt    = 1'b0;
      next_moving = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (on_s) begin
               next_state = ST_ARM;
               hold_nxt   = CNT_W'(1);
            end
         end
         ST_ARM: begin
            if (!on_s) begin
               next_state = ST_OFF;
               hold_nxt   = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               next_state = ST_ON;
               idle_nxt   = '0;
            end else begin
               hold_nxt = hold_cnt + CNT_W'(1);
            end
         end
         ST_ON: begin
            // Kill key outranks the idle timeout, so auto_off stays low then.
            if (off_s) begin
               next_state = ST_WAIT_REL;
            end else if ((idle_cnt == IDLE_LAST) && !drive_req) begin
               next_state = ST_WAIT_REL;
               auto_nxt   = 1'b1;
            end
            next_moving = (next_state == ST_ON) & drive_req;
            idle_nxt    = next_moving ? '0 : idle_cnt + CNT_W'(1);
         end
         ST_WAIT_REL: begin
            // Both keys must be released so a held key cannot re-arm.
            if (!on_s && !off_s) begin
               next_state = ST_OFF;
            end
         end
         default: next_state = ST_OFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_OFF;
         hold_cnt <= '0;
         idle_cnt <= '0;
         activate <= 1'b0;
         moving   <= 1'b0;
         auto_off <= 1'b0;
      end else begin
         state_q  <= next_state;
         hold_cnt <= hold_nxt;
         idle_cnt <= idle_nxt;
         activate <= (next_state == ST_ON);
         moving   <= next_moving;
         auto_off <= auto_nxt;
      end
   end

   assign state = state_q;

endmodule
